// File: rtl/store_buffer.sv
// In-order store write buffer between the MEM stage and the data memory write port.
// Drains one store per cycle when the port is free and flags loads that hit a pending store.
module store_buffer #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_op,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hazard,
  input  logic             mem_busy,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  output logic [1:0]       mem_op,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  op;
    logic        valid;
  } entry_t;

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;
  logic               addr_hit;

  // Fullness is judged from count alone so a full buffer never relies on a same-cycle pop.
  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push     = st_valid && st_ready;
  assign pop      = !empty && !mem_busy;

  assign mem_we   = pop;
  assign mem_addr = entries[rd_ptr].addr;
  assign mem_wd   = entries[rd_ptr].data;
  assign mem_op   = entries[rd_ptr].op;

  // Word-granular match against every pending entry plus the store arriving this cycle.
  always_comb begin
    addr_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].addr[31:2] == ld_addr[31:2])) begin
        addr_hit = 1'b1;
      end
    end
    if (push && (st_addr[31:2] == ld_addr[31:2])) begin
      addr_hit = 1'b1;
    end
    ld_hazard = ld_valid && addr_hit;
  end

  // Entry storage: retire clears the head, push fills the tail (never the same slot).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (pop) begin
        entries[rd_ptr].valid <= 1'b0;
      end
      if (push) begin
        entries[wr_ptr] <= '{addr: st_addr, data: st_data, op: st_op, valid: 1'b1};
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_store_buffer;

  logic        CLK;
  logic        RST_N;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_op;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_busy;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [1:0]  mem_op;
  logic [2:0]  count;
  logic        empty;

  int passed;
  int total;

  store_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_op(st_op),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_op(mem_op), .count(count), .empty(empty)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic idle_inputs();
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_op    = 2'b00;
    ld_valid = 1'b0;
    ld_addr  = '0;
    mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle_inputs();
    #3;
    total++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready: got %b expected 1", st_ready); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else passed++;
    total++; if (ld_hazard !== 1'b0) $display("FAIL reset_ld_hazard: got %b expected 0", ld_hazard); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_single_push();
    @(negedge CLK);
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_op = 2'b00;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL single_no_bypass: got %b expected 0", mem_we); else passed++;
    @(negedge CLK);
    st_valid = 1'b0;
    #1;
    total++; if (mem_we !== 1'b1) $display("FAIL single_mem_we: got %b expected 1", mem_we); else passed++;
    total++; if (mem_addr !== 32'h100) $display("FAIL single_mem_addr: got %h expected 00000100", mem_addr); else passed++;
    total++; if (mem_wd !== 32'hDEADBEEF) $display("FAIL single_mem_wd: got %h expected deadbeef", mem_wd); else passed++;
    total++; if (mem_op !== 2'b00) $display("FAIL single_mem_op: got %b expected 00", mem_op); else passed++;
    @(negedge CLK);
    #1;
    total++; if (empty !== 1'b1) $display("FAIL single_empty: got %b expected 1", empty); else passed++;
    total++; if (count !== 3'd0) $display("FAIL single_count: got %0d expected 0", count); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL single_we_after: got %b expected 0", mem_we); else passed++;
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      mem_busy = 1'b1;
      st_valid = 1'b1; st_addr = 32'h400 + 32'(4 * k); st_data = 32'hA0 + 32'(k); st_op = 2'b10;
      #1;
      if (k == 3) begin
        total++; if (st_ready !== 1'b1) $display("FAIL full_ready_at3: got %b expected 1", st_ready); else passed++;
      end
      if (k == 4) begin
        total++; if (st_ready !== 1'b0) $display("FAIL full_ready_at4: got %b expected 0", st_ready); else passed++;
        total++; if (count !== 3'd4) $display("FAIL full_count_at4: got %0d expected 4", count); else passed++;
      end
    end
    @(negedge CLK);
    st_valid = 1'b0;
    #1;
    total++; if (count !== 3'd4) $display("FAIL full_count_hold: got %0d expected 4", count); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL full_busy_no_we: got %b expected 0", mem_we); else passed++;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      mem_busy = 1'b0;
      #1;
      total++; if (mem_we !== 1'b1) $display("FAIL full_drain_we%0d: got %b expected 1", j, mem_we); else passed++;
      total++; if (mem_wd !== 32'hA0 + 32'(j)) $display("FAIL full_drain_wd%0d: got %h expected %h", j, mem_wd, 32'hA0 + 32'(j)); else passed++;
      total++; if (mem_addr !== 32'h400 + 32'(4 * j)) $display("FAIL full_drain_addr%0d: got %h expected %h", j, mem_addr, 32'h400 + 32'(4 * j)); else passed++;
    end
    @(negedge CLK);
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL full_fifth_dropped: got %b expected 0", mem_we); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL full_empty_end: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_hazard();
    @(negedge CLK);
    mem_busy = 1'b1;
    st_valid = 1'b1; st_addr = 32'h203; st_data = 32'h5A; st_op = 2'b01;
    @(negedge CLK);
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h200;
    #1;
    total++; if (ld_hazard !== 1'b1) $display("FAIL hazard_same_word: got %b expected 1", ld_hazard); else passed++;
    ld_addr = 32'h204;
    #1;
    total++; if (ld_hazard !== 1'b0) $display("FAIL hazard_next_word: got %b expected 0", ld_hazard); else passed++;
    ld_valid = 1'b0; ld_addr = 32'h200;
    #1;
    total++; if (ld_hazard !== 1'b0) $display("FAIL hazard_no_ld_valid: got %b expected 0", ld_hazard); else passed++;
    @(negedge CLK);
    mem_busy = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h200;
    #1;
    total++; if (ld_hazard !== 1'b1) $display("FAIL hazard_while_popping: got %b expected 1", ld_hazard); else passed++;
    total++; if (mem_op !== 2'b01) $display("FAIL hazard_mem_op: got %b expected 01", mem_op); else passed++;
    @(negedge CLK);
    #1;
    total++; if (ld_hazard !== 1'b0) $display("FAIL hazard_after_drain: got %b expected 0", ld_hazard); else passed++;
    ld_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [5];
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      mem_busy = 1'b1;
      st_valid = 1'b1; st_addr = 32'h600 + 32'(4 * k); st_data = exp_q[k]; st_op = 2'b00;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      mem_busy = 1'b0;
      st_valid = 1'b1; st_addr = 32'h608 + 32'(4 * k); st_data = exp_q[k + 2];
      #1;
      total++; if (count !== 3'd2) $display("FAIL b2b_count%0d: got %0d expected 2", k, count); else passed++;
      total++; if (mem_wd !== exp_q[k]) $display("FAIL b2b_wd%0d: got %h expected %h", k, mem_wd, exp_q[k]); else passed++;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      st_valid = 1'b0;
      #1;
      total++; if (count !== 3'(2 - k)) $display("FAIL b2b_tail_count%0d: got %0d expected %0d", k, count, 2 - k); else passed++;
      total++; if (mem_wd !== exp_q[k + 3]) $display("FAIL b2b_tail_wd%0d: got %h expected %h", k, mem_wd, exp_q[k + 3]); else passed++;
    end
    @(negedge CLK);
    #1;
    total++; if (empty !== 1'b1) $display("FAIL b2b_empty: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_same_cycle_hazard();
    @(negedge CLK);
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h77; st_op = 2'b00;
    ld_valid = 1'b1; ld_addr = 32'h302;
    #1;
    total++; if (ld_hazard !== 1'b1) $display("FAIL same_cycle_hazard: got %b expected 1", ld_hazard); else passed++;
    @(negedge CLK);
    st_valid = 1'b0; ld_valid = 1'b0;
    @(negedge CLK);
    #1;
    total++; if (empty !== 1'b1) $display("FAIL same_cycle_drained: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      mem_busy = 1'b1;
      st_valid = 1'b1; st_addr = 32'h800 + 32'(4 * k); st_data = 32'hC0 + 32'(k);
    end
    @(negedge CLK);
    st_valid = 1'b0; mem_busy = 1'b0;
    #1;
    total++; if (count !== 3'd3) $display("FAIL arst_count_before: got %0d expected 3", count); else passed++;
    total++; if (mem_we !== 1'b1) $display("FAIL arst_we_before: got %b expected 1", mem_we); else passed++;
    #2;
    RST_N = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL arst_we_drop: got %b expected 0", mem_we); else passed++;
    total++; if (count !== 3'd0) $display("FAIL arst_count: got %0d expected 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL arst_empty: got %b expected 1", empty); else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      #1;
      total++; if (mem_we !== 1'b0) $display("FAIL arst_no_write%0d: got %b expected 0", k, mem_we); else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single_push();
    test_full();
    test_hazard();
    test_back_to_back();
    test_same_cycle_hazard();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
